ip_2port_ram: RTL and testbench

Self-exercising demo block built around a simple dual-port RAM: one write port, one read port, same clock. An internal controller repeatedly fills the whole RAM with a known pattern, reads every word back and checks it against the expected value. Results appear on status outputs for simulation probing and logic-analyser capture. Only clock and reset need to be driven; all other ports are observe-only outputs.

---
 rtl/ip_2port_ram_pkg.sv | 18 +
 rtl/ip_2port_ram_sdp_ram.sv | 38 +++
 rtl/ip_2port_ram.sv | 112 +++++++++++
 tb/tb_ip_2port_ram.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ip_2port_ram_pkg.sv
// Shared definitions for the self-exercising dual-port RAM demo.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   DEPTH_DEF               : default RAM depth (2**ADDR_W_DEF)
//   state_e                 : controller phase encoding
package ip_2port_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK_TAIL
  } state_e;

endpackage

// File: rtl/ip_2port_ram_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port
// (1-cycle latency), single clock. The storage array is not reset; only the
// read data register is, so the output reads 0 out of reset.
//   clk, rst                    : clock, async active-high reset
//   wr_en, wr_addr, wr_data     : write port
//   rd_en, rd_addr              : read request
//   rd_data                     : word at rd_addr, one cycle after rd_en
module ip_2port_ram_sdp_ram
  import ip_2port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds its last value when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ip_2port_ram.sv
// Self-exercising demo around a simple dual-port RAM. A controller fills the
// RAM with (addr + offset), reads every word back, and checks each word one
// cycle after it appears on the read port. Each pass is 66 cycles:
// IDLE(1) WRITE(32) READ(32) CHECK_TAIL(1); offset advances once per pass.
//   clk, rst       : clock, async active-high reset
//   ram_wr_*       : registered write-port signals (also drive the RAM)
//   ram_rd_en/addr : registered read request (also drive the RAM)
//   ram_rd_data    : RAM read data, valid one cycle after ram_rd_en
//   pass_cnt       : completed passes, wraps at 255
//   err            : sticky mismatch flag, cleared only by reset
module ip_2port_ram
  import ip_2port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [DATA_W-1:0] ram_rd_data,
  output logic [7:0]        pass_cnt,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] offset;
  logic              chk_vld;
  logic [DATA_W-1:0] chk_exp;

  // Controller: the RAM port signals are registered from the state, so each
  // port goes active one cycle after the FSM enters the matching phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      offset      <= '0;
      pass_cnt    <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      case (state)
        ST_IDLE: begin
          cnt   <= '0;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          ram_wr_en   <= 1'b1;
          ram_wr_addr <= cnt;
          ram_wr_data <= DATA_W'(cnt) + offset;
          cnt         <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) state <= ST_READ;
        end
        ST_READ: begin
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= cnt;
          cnt         <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) state <= ST_CHECK_TAIL;
        end
        ST_CHECK_TAIL: begin
          pass_cnt <= pass_cnt + 8'd1;
          offset   <= offset + DATA_W'(1);
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ip_2port_ram_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Checker: the expected word travels alongside the read so the compare is
  // immune to offset advancing while the final word is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_vld <= 1'b0;
      chk_exp <= '0;
      err     <= 1'b0;
    end else begin
      chk_vld <= ram_rd_en;
      chk_exp <= DATA_W'(ram_rd_addr) + offset;
      if (chk_vld && (ram_rd_data != chk_exp)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ip_2port_ram.sv
// Bench for ip_2port_ram: hand-derived vector table for the first three
// passes, a cycle-indexed arithmetic reference model checked every cycle,
// an injected RAM corruption, and randomly timed mid-pass resets.
module tb_ip_2port_ram;
  import ip_2port_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_wr_en;
  logic [4:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_rd_en;
  logic [4:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic [7:0] pass_cnt;
  logic       err;

  ip_2port_ram #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .pass_cnt    (pass_cnt),
    .err         (err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          n;
    logic [36:0] exp;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         n = 0;          // rising edges since reset release
  int         corrupt_n = 0;  // edge on which corrupted data shows, 0 = none
  logic [7:0] corrupt_val = '0;
  int         wr_hi0 = 0;
  vec_t       tbl [13];

  function automatic logic [36:0] pk(logic we, logic [4:0] wa, logic [7:0] wd,
                                     logic re, logic [4:0] ra, logic [7:0] rdd,
                                     logic [7:0] pc, logic e);
    return {we, wa, wd, re, ra, rdd, pc, e};
  endfunction

  function automatic logic [36:0] obs();
    return pk(ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
              ram_rd_data, pass_cnt, err);
  endfunction

  // Expected outputs after edge k, from the pass number and position in pass.
  function automatic logic [36:0] model(int k);
    int p, j;
    logic we, re, e;
    logic [4:0] wa, ra;
    logic [7:0] wd, rdd, pc;
    if (k == 0) return '0;
    p   = (k - 1) / 66;
    j   = (k - 1) % 66 + 1;
    we  = (j >= 2 && j <= 33);
    wa  = we ? 5'(j - 2) : 5'd0;
    wd  = we ? 8'(j - 2 + p) : 8'd0;
    re  = (j >= 34 && j <= 65);
    ra  = re ? 5'(j - 34) : 5'd0;
    if (j >= 35)    rdd = 8'(j - 35 + p);
    else if (p > 0) rdd = 8'(31 + p - 1);
    else            rdd = 8'd0;
    if (corrupt_n != 0 && k == corrupt_n) rdd = corrupt_val;
    pc  = 8'(k / 66);
    e   = (corrupt_n != 0 && k > corrupt_n);
    return pk(we, wa, wd, re, ra, rdd, pc, e);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  // One clock: advance past the rising edge, sample on the falling edge.
  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    if (n <= 66 && ram_wr_en) wr_hi0++;
    chk("model", 64'(obs()), 64'(model(n)));
  endtask

  task automatic async_reset(int hold);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", 64'(obs()), 64'd0);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    n = 0;
    corrupt_n = 0;
  endtask

  initial begin
    int addr, j;

    tbl[0]  = '{1,   pk(0, 0,  0,  0, 0,  0,  0, 0)};
    tbl[1]  = '{2,   pk(1, 0,  0,  0, 0,  0,  0, 0)};
    tbl[2]  = '{17,  pk(1, 15, 15, 0, 0,  0,  0, 0)};
    tbl[3]  = '{33,  pk(1, 31, 31, 0, 0,  0,  0, 0)};
    tbl[4]  = '{34,  pk(0, 0,  0,  1, 0,  0,  0, 0)};
    tbl[5]  = '{36,  pk(0, 0,  0,  1, 2,  1,  0, 0)};
    tbl[6]  = '{65,  pk(0, 0,  0,  1, 31, 30, 0, 0)};
    tbl[7]  = '{66,  pk(0, 0,  0,  0, 0,  31, 1, 0)};
    tbl[8]  = '{67,  pk(0, 0,  0,  0, 0,  31, 1, 0)};
    tbl[9]  = '{68,  pk(1, 0,  1,  0, 0,  31, 1, 0)};
    tbl[10] = '{132, pk(0, 0,  0,  0, 0,  32, 2, 0)};
    tbl[11] = '{165, pk(1, 31, 33, 0, 0,  32, 2, 0)};
    tbl[12] = '{198, pk(0, 0,  0,  0, 0,  33, 3, 0)};

    // Reset held for 200 ns, released on a falling edge.
    repeat (5) @(negedge clk);
    chk("reset_mid", 64'(obs()), 64'd0);
    repeat (5) @(negedge clk);
    chk("reset_end", 64'(obs()), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      while (n < tbl[i].n) step();
      chk($sformatf("vec%0d", tbl[i].n), 64'(obs()), 64'(tbl[i].exp));
    end
    chk("wr_en_cycles_pass0", 64'(wr_hi0), 64'd32);

    // Corrupt one word of pass 3 after its write phase, before it is read.
    while (n < 233) step();
    addr = int'($urandom_range(1, 30));
    corrupt_val = ~8'(addr + 3);
    corrupt_n = 233 + addr;
    dut.u_ram.mem[addr] = corrupt_val;
    while (n < 400) begin
      step();
      if (n == corrupt_n)     chk("err_before", 64'(err), 64'd0);
      if (n == corrupt_n + 1) chk("err_set", 64'(err), 64'd1);
    end
    chk("err_sticky", 64'(err), 64'd1);

    // Randomly placed resets inside the write phase, then one clean pass.
    for (int r = 0; r < 3; r++) begin
      j = int'($urandom_range(3, 32));
      for (int b = 0; b < 70 && ((n - 1) % 66 + 1) != j; b++) step();
      chk("rst_point_wr_en", 64'(ram_wr_en), 64'd1);
      async_reset(int'($urandom_range(1, 4)));
      repeat (66) step();
      chk("after_rst_pass_cnt", 64'(pass_cnt), 64'd1);
      chk("after_rst_err", 64'(err), 64'd0);
      repeat (int'($urandom_range(0, 40))) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
